// File: rtl/multdiv_issue.sv
// multdiv_issue: issue/capture stage in front of the iterative multdiv unit.
// Define MULTDIV_TIMEOUT_EN to compile in the BUSY-wait watchdog (TIMEOUT cycles).
module multdiv_issue #(
    parameter int TIMEOUT = 40,
    parameter int RD_W    = 5
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_mult,
    input  logic            in_is_div,
    input  logic [31:0]     in_opA,
    input  logic [31:0]     in_opB,
    input  logic [RD_W-1:0] in_rd,
    output logic [31:0]     md_operandA,
    output logic [31:0]     md_operandB,
    output logic            md_ctrl_MULT,
    output logic            md_ctrl_DIV,
    input  logic [31:0]     md_result,
    input  logic            md_exception,
    input  logic            md_resultRDY,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            out_exception,
    output logic [RD_W-1:0] out_rd,
    output logic            out_timeout,
    output logic            stall,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [31:0]     data_q, data_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            is_mult_q, is_mult_d;
    logic            blank_q, blank_d;
    logic            exc_q, exc_d;
    logic            rdy_qual;

`ifdef MULTDIV_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       tout_q, tout_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_* is taken only in IDLE, out_* is held stable in DONE until taken.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        data_d    = data_q;
        rd_d      = rd_q;
        is_mult_d = is_mult_q;
        blank_d   = blank_q;
        exc_d     = exc_q;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d     = cnt_q;
        tout_d    = tout_q;
`endif
        // RDY may still be asserted from the previous operation in the first BUSY cycle.
        rdy_qual  = (state_q == S_BUSY) && !blank_q && md_resultRDY;

        case (state_q)
            S_IDLE: begin
                if (in_valid && (in_is_mult || in_is_div)) begin
                    state_d   = S_START;
                    op_a_d    = in_opA;
                    op_b_d    = in_opB;
                    rd_d      = in_rd;
                    is_mult_d = in_is_mult;
                end
            end
            S_START: begin
                state_d = S_BUSY;
                blank_d = 1'b1;
`ifdef MULTDIV_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            S_BUSY: begin
                blank_d = 1'b0;
                if (rdy_qual) begin
                    state_d = S_DONE;
                    data_d  = md_result;
                    exc_d   = md_exception;
`ifdef MULTDIV_TIMEOUT_EN
                    tout_d  = 1'b0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_DONE;
                    data_d  = 32'd0;
                    exc_d   = 1'b1;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            op_a_q    <= 32'd0;
            op_b_q    <= 32'd0;
            data_q    <= 32'd0;
            rd_q      <= '0;
            is_mult_q <= 1'b0;
            blank_q   <= 1'b0;
            exc_q     <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q     <= 8'd0;
            tout_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            data_q    <= data_d;
            rd_q      <= rd_d;
            is_mult_q <= is_mult_d;
            blank_q   <= blank_d;
            exc_q     <= exc_d;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
`endif
        end
    end

    // Start pulses decode the state register directly, so reset kills them at once.
    assign md_ctrl_MULT  = (state_q == S_START) && is_mult_q;
    assign md_ctrl_DIV   = (state_q == S_START) && !is_mult_q;
    assign md_operandA   = op_a_q;
    assign md_operandB   = op_b_q;
    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign out_data      = data_q;
    assign out_exception = exc_q;
    assign out_rd        = rd_q;
    assign stall         = (state_q == S_START) || (state_q == S_BUSY) ||
                           ((state_q == S_DONE) && !out_ready);
    assign dbg_state     = state_q;
`ifdef MULTDIV_TIMEOUT_EN
    assign out_timeout   = tout_q;
`else
    assign out_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: vector table plus hand sequences for
// backpressure, reset mid-operation, rejected requests and the optional watchdog.
module tb_multdiv_issue;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_mult;
    logic        in_is_div;
    logic [31:0] in_opA;
    logic [31:0] in_opB;
    logic [4:0]  in_rd;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_exception;
    logic [4:0]  out_rd;
    logic        out_timeout;
    logic        stall;
    logic [1:0]  dbg_state;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
    localparam int LONG_RDY   = 9;
`else
    localparam int TB_TIMEOUT = 40;
    localparam int LONG_RDY   = 36;
`endif

    multdiv_issue #(.TIMEOUT(TB_TIMEOUT), .RD_W(5)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_mult(in_is_mult), .in_is_div(in_is_div),
        .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_exception(out_exception), .out_rd(out_rd),
        .out_timeout(out_timeout), .stall(stall), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        is_mult;
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          rdy;       // cycle (accept edge = 0) where the model raises RDY
        bit          stale;     // RDY left high through cycles 0..2
        logic [31:0] res;       // value the multdiv model returns
        logic        exc;
        logic        exp_mp;
        logic        exp_dp;
        int          exp_vc;    // cycle in which out_valid must first be seen
        logic [31:0] exp_data;
        logic        exp_exc;
        logic        exp_tout;
    } vec_t;

    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=hung required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_md(input vec_t v, input int c);
        md_resultRDY = (c == v.rdy) || (v.stale && c <= 2);
        md_result    = (c == v.rdy) ? v.res : 32'hDEAD_BEEF;
        md_exception = (c == v.rdy) ? v.exc : 1'b1;
    endtask

    // Called #1 after a rising edge with the stage in IDLE; that cycle is cycle 0.
    task automatic run_to_valid(input vec_t v, output int vcyc);
        bit mp_ok, dp_ok, st_ok, op_ok;
        mp_ok = 1'b1; dp_ok = 1'b1; st_ok = 1'b1; op_ok = 1'b1;
        vcyc = -1;
        in_valid   = 1'b1;
        in_is_mult = v.is_mult;
        in_is_div  = v.is_div;
        in_opA     = v.a;
        in_opB     = v.b;
        in_rd      = v.rd;
        drive_md(v, 0);
        for (int c = 0; c < 200; c++) begin
            if (c > 0) begin
                @(posedge clock); #1;
                in_valid = 1'b0;
                drive_md(v, c);
            end
            @(negedge clock);
            if (c == 0) chk("in_ready_c0", {31'd0, in_ready}, 32'd1);
            mp_ok &= (md_ctrl_MULT === ((c == 1) && v.exp_mp));
            dp_ok &= (md_ctrl_DIV === ((c == 1) && v.exp_dp));
            st_ok &= (stall === ((c >= 1) && !(out_valid && out_ready)));
            if (c >= 1) op_ok &= (md_operandA === v.a) && (md_operandB === v.b);
            if (out_valid === 1'b1) begin
                vcyc = c;
                break;
            end
        end
        chk("valid_cycle", vcyc, v.exp_vc);
        chk("out_data", out_data, v.exp_data);
        chk("out_exception", {31'd0, out_exception}, {31'd0, v.exp_exc});
        chk("out_rd", {27'd0, out_rd}, {27'd0, v.rd});
        chk("out_timeout", {31'd0, out_timeout}, {31'd0, v.exp_tout});
        chk("mult_pulse", {31'd0, mp_ok}, 32'd1);
        chk("div_pulse", {31'd0, dp_ok}, 32'd1);
        chk("stall", {31'd0, st_ok}, 32'd1);
        chk("operands_held", {31'd0, op_ok}, 32'd1);
    endtask

    // With out_ready high, DONE lasts exactly one cycle and IDLE follows.
    task automatic drain();
        @(posedge clock); #1;
        md_resultRDY = 1'b0;
        md_result    = 32'd0;
        md_exception = 1'b0;
        @(negedge clock);
        chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
    endtask

    vec_t tbl[6];
    vec_t bp, nx, rv, wd;
    int   vc;
    bit   ok;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'd6, 32'd7, 5'd3, LONG_RDY, 1'b0, 32'd42, 1'b0,
                   1'b1, 1'b0, LONG_RDY + 1, 32'd42, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 5'd17, 6, 1'b1, 32'hFFFF_FFF1, 1'b0,
                   1'b1, 1'b0, 7, 32'hFFFF_FFF1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd31, 3, 1'b0, 32'd0, 1'b1,
                   1'b1, 1'b0, 4, 32'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'd100, 32'd7, 5'd9, 5, 1'b0, 32'd14, 1'b0,
                   1'b0, 1'b1, 6, 32'd14, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'd8, 32'd8, 5'd1, 4, 1'b0, 32'd64, 1'b0,
                   1'b1, 1'b0, 5, 32'd64, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'd5, 32'd0, 5'd2, 3, 1'b0, 32'd0, 1'b1,
                   1'b0, 1'b1, 4, 32'd0, 1'b1, 1'b0};
        bp = '{1'b1, 1'b0, 32'd9, 32'd9, 5'd12, 5, 1'b0, 32'd81, 1'b0,
               1'b1, 1'b0, 6, 32'd81, 1'b0, 1'b0};
        nx = '{1'b0, 1'b1, 32'd50, 32'd5, 5'd20, 3, 1'b0, 32'd10, 1'b0,
               1'b0, 1'b1, 4, 32'd10, 1'b0, 1'b0};
        rv = '{1'b1, 1'b0, 32'd12, 32'd12, 5'd5, 4, 1'b0, 32'd144, 1'b0,
               1'b1, 1'b0, 5, 32'd144, 1'b0, 1'b0};
        wd = '{1'b1, 1'b0, 32'd3, 32'd3, 5'd7, 1000, 1'b0, 32'd9, 1'b0,
               1'b1, 1'b0, TB_TIMEOUT + 2, 32'd0, 1'b1, 1'b1};

        // Reset state
        resetn = 1'b0; in_valid = 1'b0; in_is_mult = 1'b0; in_is_div = 1'b0;
        in_opA = 32'd0; in_opB = 32'd0; in_rd = 5'd0; out_ready = 1'b1;
        md_result = 32'd0; md_exception = 1'b0; md_resultRDY = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pulses", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_operandA", md_operandA, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;

        // Request with neither op flag is ignored
        ok = 1'b1;
        in_valid = 1'b1; in_opA = 32'd1; in_opB = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            ok &= (in_ready === 1'b1) && (md_ctrl_MULT === 1'b0) && (md_ctrl_DIV === 1'b0)
                  && (stall === 1'b0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        chk("no_flag_ignored", {31'd0, ok}, 32'd1);
        chk("no_flag_state", {30'd0, dbg_state}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_to_valid(tbl[i], vc);
            drain();
        end

        // Backpressure: out_ready low for 5 DONE cycles with a new request waiting
        out_ready = 1'b0;
        run_to_valid(bp, vc);
        ok = 1'b1;
        for (int h = 0; h < 5; h++) begin
            if (h > 0) @(negedge clock);
            ok &= (out_valid === 1'b1) && (out_data === bp.exp_data) && (stall === 1'b1)
                  && (in_ready === 1'b0);
            @(posedge clock); #1;
            md_resultRDY = 1'b0;
            in_valid = 1'b1; in_is_mult = nx.is_mult; in_is_div = nx.is_div;
            in_opA = nx.a; in_opB = nx.b; in_rd = nx.rd;
        end
        chk("bp_hold", {31'd0, ok}, 32'd1);
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_release_stall", {31'd0, stall}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        run_to_valid(nx, vc);
        drain();

        // Reset during the third BUSY cycle
        in_valid = 1'b1; in_is_mult = 1'b1; in_is_div = 1'b0;
        in_opA = 32'd11; in_opB = 32'd13; in_rd = 5'd7; md_resultRDY = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        resetn = 1'b0;
        #2;
        chk("mid_rst_pulses", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        run_to_valid(rv, vc);
        drain();

`ifdef MULTDIV_TIMEOUT_EN
        run_to_valid(wd, vc);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
